// File: rtl/uart_autobaud.sv
// Automatic baud-rate configurator: measures a 0x55 sync character on the
// raw rxd line, derives the receiver prescale word, and supervises lock
// using the receiver's frame_error/good pulses.
module uart_autobaud #(
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd54,
  parameter int unsigned CNT_WIDTH        = 24,
  parameter logic [15:0] MIN_IDLE         = 16'd64,
  parameter int unsigned FE_LIMIT         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        enable,
  input  logic        relock,
  input  logic        rx_frame_error,
  input  logic        rx_good,
  output logic [15:0] prescale,
  output logic        locked,
  output logic        busy,
  output logic        lock_error
);

  localparam int unsigned SUM_W  = CNT_WIDTH + 3;
  // Wide enough for the rounded sum and always above bit 15, so the
  // overflow test below is legal for any counter width.
  localparam int unsigned WIDE_W = (SUM_W + 1 > 22) ? SUM_W + 1 : 22;
  localparam int unsigned FE_W   = $clog2(FE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_MEASURE,
    ST_STOP,
    ST_LOCKED
  } state_t;

  state_t               state_q, state_d;
  logic                 rxd_meta_q, rxd_meta_d;
  logic                 rxd_s_q, rxd_s_d;
  logic                 rxd_d1_q, rxd_d1_d;
  logic [15:0]          idle_q, idle_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] t0_q, t0_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [3:0]           edge_idx_q, edge_idx_d;
  logic [FE_W-1:0]      fe_q, fe_d;
  logic [15:0]          prescale_q, prescale_d;
  logic                 locked_q, locked_d;
  logic                 lock_error_q, lock_error_d;

  logic                 fall, rise, any_edge;
  logic                 cnt_at_max;
  logic [CNT_WIDTH-1:0] ref_t, diff_t, stop_len;
  logic                 out_of_tol;
  logic [WIDE_W-1:0]    ps_wide;
  logic                 ps_bad;
  logic [FE_W-1:0]      fe_inc;
  logic                 abort, drop;

  // Edge detection, interval tolerance and prescale derivation
  always_comb begin
    fall       = rxd_d1_q & ~rxd_s_q;
    rise       = ~rxd_d1_q & rxd_s_q;
    any_edge   = fall | rise;
    cnt_at_max = (cnt_q == '1);
    // The first interval is compared against itself so it always passes.
    ref_t      = (edge_idx_q == 4'd0) ? cnt_q : t0_q;
    diff_t     = (cnt_q >= ref_t) ? (cnt_q - ref_t) : (ref_t - cnt_q);
    out_of_tol = (diff_t > (ref_t >> 2));
    stop_len   = t0_q - (t0_q >> 2);
    ps_wide    = (WIDE_W'(sum_q) + WIDE_W'(32)) >> 6;
    ps_bad     = (ps_wide == '0) || (|ps_wide[WIDE_W-1:16]);
    fe_inc     = fe_q + 1'b1;
  end

  // Next-state and register updates for the hunt/measure/stop/lock FSM
  always_comb begin
    state_d      = state_q;
    rxd_meta_d   = rxd;
    rxd_s_d      = rxd_meta_q;
    rxd_d1_d     = rxd_s_q;
    idle_d       = idle_q;
    cnt_d        = cnt_q;
    t0_d         = t0_q;
    sum_d        = sum_q;
    edge_idx_d   = edge_idx_q;
    fe_d         = fe_q;
    prescale_d   = prescale_q;
    locked_d     = locked_q;
    lock_error_d = 1'b0;
    abort        = 1'b0;
    drop         = 1'b0;

    if (relock) begin
      drop = 1'b1;
    end else if (!enable) begin
      state_d    = ST_HUNT;
      locked_d   = 1'b0;
      idle_d     = '0;
      cnt_d      = '0;
      t0_d       = '0;
      sum_d      = '0;
      edge_idx_d = '0;
      fe_d       = '0;
    end else begin
      unique case (state_q)
        ST_HUNT: begin
          if (fall) begin
            idle_d = '0;
            if (idle_q >= MIN_IDLE) begin
              state_d    = ST_MEASURE;
              cnt_d      = CNT_WIDTH'(1);
              edge_idx_d = '0;
              sum_d      = '0;
            end
          end else if (rxd_s_q) begin
            idle_d = (idle_q == '1) ? idle_q : idle_q + 16'd1;
          end else begin
            idle_d = '0;
          end
        end

        ST_MEASURE: begin
          if (any_edge) begin
            if (out_of_tol) begin
              abort = 1'b1;
            end else begin
              if (edge_idx_q == 4'd0) t0_d = cnt_q;
              if (edge_idx_q <= 4'd7) sum_d = sum_q + SUM_W'(cnt_q);
              cnt_d = CNT_WIDTH'(1);
              if (edge_idx_q == 4'd8) begin
                state_d    = ST_STOP;
                edge_idx_d = '0;
              end else begin
                edge_idx_d = edge_idx_q + 4'd1;
              end
            end
          end else if (cnt_at_max) begin
            abort = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (fall) begin
            abort = 1'b1;
          end else if (cnt_q >= stop_len) begin
            if (ps_bad) begin
              abort = 1'b1;
            end else begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              prescale_d = ps_wide[15:0];
              fe_d       = '0;
              cnt_d      = '0;
              sum_d      = '0;
            end
          end else if (cnt_at_max) begin
            abort = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_LOCKED: begin
          if (rx_good) begin
            fe_d = '0;
          end else if (rx_frame_error) begin
            if (fe_inc == FE_W'(FE_LIMIT)) drop = 1'b1;
            else fe_d = fe_inc;
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end

    // Lock loss and rejected attempts share their cleanup; a rejected
    // attempt leaves prescale/locked exactly as they were.
    if (drop) begin
      state_d    = ST_HUNT;
      locked_d   = 1'b0;
      prescale_d = DEFAULT_PRESCALE;
      fe_d       = '0;
      idle_d     = '0;
      cnt_d      = '0;
      sum_d      = '0;
      edge_idx_d = '0;
    end
    if (abort) begin
      state_d      = ST_HUNT;
      lock_error_d = 1'b1;
      idle_d       = '0;
      cnt_d        = '0;
      sum_d        = '0;
      edge_idx_d   = '0;
    end
  end

  // State register with asynchronous reset; line flops idle high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      rxd_d1_q     <= 1'b1;
      idle_q       <= '0;
      cnt_q        <= '0;
      t0_q         <= '0;
      sum_q        <= '0;
      edge_idx_q   <= '0;
      fe_q         <= '0;
      prescale_q   <= DEFAULT_PRESCALE;
      locked_q     <= 1'b0;
      lock_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rxd_meta_q   <= rxd_meta_d;
      rxd_s_q      <= rxd_s_d;
      rxd_d1_q     <= rxd_d1_d;
      idle_q       <= idle_d;
      cnt_q        <= cnt_d;
      t0_q         <= t0_d;
      sum_q        <= sum_d;
      edge_idx_q   <= edge_idx_d;
      fe_q         <= fe_d;
      prescale_q   <= prescale_d;
      locked_q     <= locked_d;
      lock_error_q <= lock_error_d;
    end
  end

  assign prescale   = prescale_q;
  assign locked     = locked_q;
  assign lock_error = lock_error_q;
  assign busy       = (state_q == ST_MEASURE) || (state_q == ST_STOP);

endmodule

// File: tb/tb_uart_autobaud.sv
// Scoreboard bench for uart_autobaud: the stimulus side predicts lock,
// reject and drop events from the sync-character rules; a monitor pops
// and compares them as the DUT produces them.
module tb_uart_autobaud;

  localparam int unsigned CW       = 12;
  localparam int unsigned CNT_MAX  = (1 << CW) - 1;
  localparam int unsigned DEF_PS   = 54;
  localparam int unsigned FE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst, rxd, enable, relock, rx_frame_error, rx_good;
  logic [15:0] prescale;
  logic        locked, busy, lock_error;

  typedef enum int {EV_LOCK, EV_ERR, EV_DROP} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned ps;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned model_ps = DEF_PS;
  bit          model_locked = 1'b0;
  int unsigned model_fe = 0;
  bit          busy_watch = 1'b0;
  logic        locked_prev = 1'b0;

  always #5 clk = ~clk;

  uart_autobaud #(
    .CNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rxd            (rxd),
    .enable         (enable),
    .relock         (relock),
    .rx_frame_error (rx_frame_error),
    .rx_good        (rx_good),
    .prescale       (prescale),
    .locked         (locked),
    .busy           (busy),
    .lock_error     (lock_error)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input int unsigned ps);
    ev_t e;
    e.kind = k;
    e.ps   = ps;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s prescale=%0d locked=%0b, expected no event",
               k.name(), prescale, locked);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || 32'(prescale) != e.ps || (k != EV_LOCK && locked !== 1'b0)) begin
        errors++;
        $display("FAIL event: got %s prescale=%0d locked=%0b, expected %s prescale=%0d",
                 k.name(), prescale, locked, e.kind.name(), e.ps);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events for the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      locked_prev = 1'b0;
    end else begin
      if (lock_error === 1'b1) observe(EV_ERR);
      if (locked === 1'b1 && locked_prev === 1'b0) observe(EV_LOCK);
      if (locked === 1'b0 && locked_prev === 1'b1) observe(EV_DROP);
      if (busy_watch) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_idle: busy=%0b expected 0", busy);
        end
      end
      locked_prev = locked;
    end
  end

  task automatic hold(input logic lvl, input int unsigned n);
    rxd = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d expected events still pending after %0d cycles",
               tag, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  // Reference: a sync attempt is judged from its interval list alone.
  // stop_high = 0 means the line stays high after the stop-bit edge.
  task automatic attempt(input int unsigned seg[9], input int unsigned stop_high,
                         input string tag);
    int          bad;
    int unsigned tol, d, sum, ps, need;
    bit          short_stop;
    bad = -1;
    tol = seg[0] / 4;
    for (int i = 0; i < 9; i++) begin
      d = (seg[i] > seg[0]) ? seg[i] - seg[0] : seg[0] - seg[i];
      if (seg[i] > CNT_MAX || d > tol) begin
        bad = i;
        break;
      end
    end
    hold(1'b1, 100);
    if (bad >= 0) begin
      expect_ev(EV_ERR, model_ps);
      for (int i = 0; i <= bad; i++) hold((i % 2 == 1) ? 1'b1 : 1'b0, seg[i]);
      if (bad % 2 == 1) hold(1'b0, 10);
      hold(1'b1, 150);
    end else begin
      sum = 0;
      for (int i = 0; i < 8; i++) sum += seg[i];
      ps         = (sum + 32) / 64;
      need       = seg[0] - seg[0] / 4;
      short_stop = (stop_high != 0) && (stop_high < need);
      if (short_stop || ps == 0 || ps > 65535) begin
        expect_ev(EV_ERR, model_ps);
      end else begin
        expect_ev(EV_LOCK, ps);
        model_ps     = ps;
        model_locked = 1'b1;
        model_fe     = 0;
      end
      for (int i = 0; i < 9; i++) hold((i % 2 == 1) ? 1'b1 : 1'b0, seg[i]);
      if (short_stop) begin
        hold(1'b1, stop_high);
        hold(1'b0, 10);
      end
      hold(1'b1, 150 + seg[0]);
    end
    wait_drain(tag);
  endtask

  task automatic do_relock();
    if (model_locked) expect_ev(EV_DROP, DEF_PS);
    model_ps     = DEF_PS;
    model_locked = 1'b0;
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    repeat (2) @(negedge clk);
    wait_drain("relock");
  endtask

  // Receiver supervision: good byte clears the error run, even alongside an error
  task automatic fe_pulse(input bit err, input bit good);
    if (model_locked) begin
      if (good) begin
        model_fe = 0;
      end else if (err) begin
        model_fe++;
        if (model_fe == FE_LIMIT) begin
          expect_ev(EV_DROP, DEF_PS);
          model_ps     = DEF_PS;
          model_locked = 1'b0;
          model_fe     = 0;
        end
      end
    end
    rx_frame_error = err;
    rx_good        = good;
    @(negedge clk);
    rx_frame_error = 1'b0;
    rx_good        = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned seg[9];
    int unsigned t, j, k, dev, stop_high, mode;

    rst = 1'b1; rxd = 1'b1; enable = 1'b1; relock = 1'b0;
    rx_frame_error = 1'b0; rx_good = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_prescale", prescale, DEF_PS);
    chk("reset_locked", locked, 0);
    chk("reset_busy", busy, 0);
    chk("reset_lock_error", lock_error, 0);
    rst = 1'b0;

    // Falling edge after too short an idle period is ignored
    busy_watch = 1'b1;
    hold(1'b1, 20);
    hold(1'b0, 30);
    hold(1'b1, 150);
    busy_watch = 1'b0;

    for (int i = 0; i < 9; i++) seg[i] = 80;
    attempt(seg, 0, "sync_t80");

    fe_pulse(1, 0); fe_pulse(1, 0); fe_pulse(1, 0);
    fe_pulse(0, 1); fe_pulse(1, 0); fe_pulse(1, 1);
    chk("fe_still_locked", locked, 1);
    fe_pulse(1, 0); fe_pulse(1, 0); fe_pulse(1, 0); fe_pulse(1, 0);
    wait_drain("fe_drop");
    chk("fe_prescale_default", prescale, DEF_PS);

    seg = '{80, 80, 110, 80, 80, 80, 80, 80, 80};
    attempt(seg, 0, "reject_110");

    for (int i = 0; i < 9; i++) seg[i] = 87;
    attempt(seg, 0, "sync_t87");

    // Disabling drops lock but keeps the measured prescale
    expect_ev(EV_DROP, model_ps);
    model_locked = 1'b0;
    enable = 1'b0;
    hold(1'b1, 10);
    enable = 1'b1;
    wait_drain("disable");

    attempt(seg, 30, "stop_short");

    seg = '{4200, 80, 80, 80, 80, 80, 80, 80, 80};
    attempt(seg, 0, "timeout");

    // Asynchronous reset in the middle of a measurement
    hold(1'b1, 100);
    for (int i = 0; i < 4; i++) hold((i % 2 == 1) ? 1'b1 : 1'b0, 80);
    hold(1'b0, 40);
    chk("busy_measure", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_prescale", prescale, DEF_PS);
    chk("midrst_locked", locked, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_lock_error", lock_error, 0);
    exp_q.delete();
    model_ps     = DEF_PS;
    model_locked = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    for (int i = 0; i < 9; i++) seg[i] = 80;
    attempt(seg, 0, "sync_after_rst");
    do_relock();

    // Randomised sync attempts: jittered, one bad interval, or a short stop bit
    for (int n = 0; n < 10; n++) begin
      t    = $urandom_range(16, 200);
      mode = $urandom_range(0, 3);
      j    = t / 16;
      for (int i = 0; i < 9; i++) seg[i] = t + $urandom_range(0, 2 * j) - j;
      if (mode == 2) begin
        k   = $urandom_range(1, 8);
        dev = t / 4 + 2 + $urandom_range(0, t / 4);
        seg[k] = ($urandom_range(0, 1) == 1) ? t + dev : t - dev;
      end
      stop_high = (mode == 3) ? (seg[0] - seg[0] / 4) / 2 : 0;
      attempt(seg, stop_high, "random");
      if (model_locked) do_relock();
    end

    repeat (20) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
